// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: pipeline stage register with optional 2-entry skid buffer and redirect bubbles
module pipe_stage_buf #(
  parameter int          DATA_W   = 32,
  parameter int          EXC_W    = 5,
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          SKID_EN  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [31:0]       in_pc,
  input  logic [EXC_W-1:0]  in_exc,
  input  logic              in_bd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [31:0]       out_pc,
  output logic [EXC_W-1:0]  out_exc,
  output logic              out_bd,
  input  logic              req,
  input  logic              eret,
  input  logic [31:0]       ebase,
  input  logic [31:0]       epc,
  input  logic              flush,
  output logic [1:0]        occupancy
);
  logic              h_valid_q, h_valid_d, s_valid_q, s_valid_d;
  logic [DATA_W-1:0] h_data_q, h_data_d, s_data_q, s_data_d;
  logic [31:0]       h_pc_q, h_pc_d, s_pc_q, s_pc_d;
  logic [EXC_W-1:0]  h_exc_q, h_exc_d, s_exc_q, s_exc_d;
  logic              h_bd_q, h_bd_d, s_bd_q, s_bd_d;
  logic              accept, pop;

  // With the skid buffer in_ready comes only from a register; without it, it sees out_ready
  assign in_ready  = (SKID_EN != 0) ? !s_valid_q : (!h_valid_q | out_ready);
  assign accept    = in_valid & in_ready;
  assign pop       = h_valid_q & out_ready;
  assign out_valid = h_valid_q;
  assign out_data  = h_data_q;
  assign out_pc    = h_pc_q;
  assign out_exc   = h_exc_q;
  assign out_bd    = h_bd_q;
  assign occupancy = {1'b0, h_valid_q} + {1'b0, s_valid_q};

  // Next-state: redirects (req > eret > flush) win over the handshake and drop any accept
  always_comb begin
    h_valid_d = h_valid_q;
    h_data_d  = h_data_q;
    h_pc_d    = h_pc_q;
    h_exc_d   = h_exc_q;
    h_bd_d    = h_bd_q;
    s_valid_d = s_valid_q;
    s_data_d  = s_data_q;
    s_pc_d    = s_pc_q;
    s_exc_d   = s_exc_q;
    s_bd_d    = s_bd_q;
    if (req | eret | flush) begin
      h_valid_d = 1'b0;
      h_data_d  = '0;
      h_exc_d   = '0;
      h_bd_d    = 1'b0;
      h_pc_d    = req ? ebase : eret ? epc : h_pc_q;
      s_valid_d = 1'b0;
    end else if (pop & s_valid_q) begin
      h_data_d  = s_data_q;
      h_pc_d    = s_pc_q;
      h_exc_d   = s_exc_q;
      h_bd_d    = s_bd_q;
      s_valid_d = 1'b0;
    end else if (accept & (!h_valid_q | pop)) begin
      h_valid_d = 1'b1;
      h_data_d  = in_data;
      h_pc_d    = in_pc;
      h_exc_d   = in_exc;
      h_bd_d    = in_bd;
    end else if ((SKID_EN != 0) && accept && h_valid_q) begin
      s_valid_d = 1'b1;
      s_data_d  = in_data;
      s_pc_d    = in_pc;
      s_exc_d   = in_exc;
      s_bd_d    = in_bd;
    end else if (pop) begin
      h_valid_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset overriding everything
  always_ff @(posedge clk) begin
    if (!reset) begin
      h_valid_q <= 1'b0;
      h_data_q  <= '0;
      h_pc_q    <= RESET_PC;
      h_exc_q   <= '0;
      h_bd_q    <= 1'b0;
      s_valid_q <= 1'b0;
      s_data_q  <= '0;
      s_pc_q    <= '0;
      s_exc_q   <= '0;
      s_bd_q    <= 1'b0;
    end else begin
      h_valid_q <= h_valid_d;
      h_data_q  <= h_data_d;
      h_pc_q    <= h_pc_d;
      h_exc_q   <= h_exc_d;
      h_bd_q    <= h_bd_d;
      s_valid_q <= s_valid_d;
      s_data_q  <= s_data_d;
      s_pc_q    <= s_pc_d;
      s_exc_q   <= s_exc_d;
      s_bd_q    <= s_bd_d;
    end
  end
endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: directed checks of skid and non-skid pipeline stage variants
module tb_pipe_stage_buf;
  logic        clk = 1'b0;
  logic        reset, in_valid, in_bd, out_ready, req, eret, flush;
  logic [31:0] in_data, in_pc, ebase, epc;
  logic [4:0]  in_exc;
  logic        s_in_ready, s_out_valid, s_out_bd, n_in_ready, n_out_valid, n_out_bd;
  logic [31:0] s_out_data, s_out_pc, n_out_data, n_out_pc;
  logic [4:0]  s_out_exc, n_out_exc;
  logic [1:0]  s_occ, n_occ;
  int          n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  pipe_stage_buf #(.SKID_EN(1)) u_skid (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .in_pc(in_pc), .in_exc(in_exc), .in_bd(in_bd),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .out_pc(s_out_pc), .out_exc(s_out_exc), .out_bd(s_out_bd),
    .req(req), .eret(eret), .ebase(ebase), .epc(epc), .flush(flush),
    .occupancy(s_occ)
  );

  pipe_stage_buf #(.SKID_EN(0)) u_noskid (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(n_in_ready),
    .in_data(in_data), .in_pc(in_pc), .in_exc(in_exc), .in_bd(in_bd),
    .out_valid(n_out_valid), .out_ready(out_ready), .out_data(n_out_data),
    .out_pc(n_out_pc), .out_exc(n_out_exc), .out_bd(n_out_bd),
    .req(req), .eret(eret), .ebase(ebase), .epc(epc), .flush(flush),
    .occupancy(n_occ)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [31:0] pc, input logic [31:0] data);
    in_valid = 1'b1;
    in_pc    = pc;
    in_data  = data;
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_bd = 1'b0; out_ready = 1'b0;
    req = 1'b0; eret = 1'b0; flush = 1'b0;
    in_data = '0; in_pc = '0; ebase = '0; epc = '0; in_exc = '0;
    tick; tick;
    chk("rst_valid", {31'b0, s_out_valid}, 32'd0);
    chk("rst_pc", s_out_pc, 32'h3000);
    chk("rst_data", s_out_data, 32'd0);
    chk("rst_occ", {30'b0, s_occ}, 32'd0);
    chk("rst_ready", {31'b0, s_in_ready}, 32'd1);
    reset = 1'b1;
    out_ready = 1'b1;
    feed(32'h3000, 32'h2402_0005);
    #1;
    chk("pre_xfer_pc", s_out_pc, 32'h3000);
    tick;
    in_valid = 1'b0;
    chk("lat_valid", {31'b0, s_out_valid}, 32'd1);
    chk("lat_data", s_out_data, 32'h2402_0005);
    chk("lat_pc", s_out_pc, 32'h3000);
    chk("lat_occ", {30'b0, s_occ}, 32'd1);
    tick;
    chk("drain_valid", {31'b0, s_out_valid}, 32'd0);
    chk("drain_pc_hold", s_out_pc, 32'h3000);
    out_ready = 1'b0;
    feed(32'h3000, 32'd1);
    tick;
    feed(32'h3004, 32'd2);
    tick;
    chk("skid_occ2", {30'b0, s_occ}, 32'd2);
    chk("skid_ready0", {31'b0, s_in_ready}, 32'd0);
    feed(32'h3008, 32'd3);
    tick;
    chk("skid_hold_occ", {30'b0, s_occ}, 32'd2);
    chk("skid_head0", s_out_pc, 32'h3000);
    out_ready = 1'b1;
    #1;
    chk("skid_ready_reg", {31'b0, s_in_ready}, 32'd0);
    tick;
    chk("skid_head1", s_out_pc, 32'h3004);
    chk("skid_head1_data", s_out_data, 32'd2);
    chk("skid_occ1", {30'b0, s_occ}, 32'd1);
    tick;
    in_valid = 1'b0;
    chk("skid_head2", s_out_pc, 32'h3008);
    chk("skid_head2_data", s_out_data, 32'd3);
    chk("skid_head2_valid", {31'b0, s_out_valid}, 32'd1);
    tick;
    chk("skid_empty", {30'b0, s_occ}, 32'd0);
    out_ready = 1'b0;
    feed(32'h3010, 32'd4);
    tick;
    feed(32'h3014, 32'd5);
    tick;
    in_valid = 1'b0;
    chk("full_occ", {30'b0, s_occ}, 32'd2);
    req = 1'b1; eret = 1'b1; ebase = 32'h4180; epc = 32'h3010;
    tick;
    req = 1'b0; eret = 1'b0;
    chk("req_valid", {31'b0, s_out_valid}, 32'd0);
    chk("req_data", s_out_data, 32'd0);
    chk("req_pc", s_out_pc, 32'h4180);
    chk("req_occ", {30'b0, s_occ}, 32'd0);
    chk("req_ready", {31'b0, s_in_ready}, 32'd1);
    eret = 1'b1; epc = 32'h300C;
    feed(32'h3020, 32'd6);
    tick;
    eret = 1'b0; in_valid = 1'b0;
    chk("eret_pc", s_out_pc, 32'h300C);
    chk("eret_valid", {31'b0, s_out_valid}, 32'd0);
    tick;
    chk("eret_drop_occ", {30'b0, s_occ}, 32'd0);
    chk("eret_drop_pc", s_out_pc, 32'h300C);
    feed(32'h3040, 32'd7);
    in_exc = 5'd5; in_bd = 1'b1;
    tick;
    in_valid = 1'b0; in_exc = '0; in_bd = 1'b0;
    chk("exc_head_pc", s_out_pc, 32'h3040);
    chk("exc_head_exc", {27'b0, s_out_exc}, 32'd5);
    chk("exc_head_bd", {31'b0, s_out_bd}, 32'd1);
    chk("exc_head_valid", {31'b0, s_out_valid}, 32'd1);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    chk("flush_valid", {31'b0, s_out_valid}, 32'd0);
    chk("flush_pc", s_out_pc, 32'h3040);
    chk("flush_occ", {30'b0, s_occ}, 32'd0);
    chk("flush_data", s_out_data, 32'd0);
    chk("flush_exc", {27'b0, s_out_exc}, 32'd0);
    chk("flush_bd", {31'b0, s_out_bd}, 32'd0);
    reset = 1'b0;
    tick;
    reset = 1'b1;
    out_ready = 1'b0;
    feed(32'h3050, 32'd8);
    tick;
    chk("ns_head_valid", {31'b0, n_out_valid}, 32'd1);
    chk("ns_ready_lo", {31'b0, n_in_ready}, 32'd0);
    feed(32'h3054, 32'd9);
    out_ready = 1'b1;
    #1;
    chk("ns_ready_t1", {31'b0, n_in_ready}, 32'd1);
    tick;
    chk("ns_head_next", n_out_pc, 32'h3054);
    out_ready = 1'b0;
    feed(32'h3058, 32'd10);
    #1;
    chk("ns_ready_t0", {31'b0, n_in_ready}, 32'd0);
    tick;
    chk("ns_occ_max1", {30'b0, n_occ}, 32'd1);
    chk("ns_hold_pc", n_out_pc, 32'h3054);
    out_ready = 1'b1;
    #1;
    chk("ns_ready_t1b", {31'b0, n_in_ready}, 32'd1);
    reset = 1'b0;
    tick;
    chk("ns_rst_valid", {31'b0, n_out_valid}, 32'd0);
    chk("ns_rst_pc", n_out_pc, 32'h3000);
    chk("ns_rst_data", n_out_data, 32'd0);
    chk("ns_rst_occ", {30'b0, n_occ}, 32'd0);
    chk("s_rst_pc", s_out_pc, 32'h3000);
    chk("s_rst_occ", {30'b0, s_occ}, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised pipeline-stage register replacing the fixed F/D stage registers.
- Carries a generic payload plus PC, exception code and branch-delay flag.
- Optional 2-entry skid buffer with valid/ready handshake, so upstream stall does not depend combinationally on downstream ready.
- Exception (req) and ERET redirects insert a bubble carrying the redirect PC, which CP0 uses as the macroscopic PC.

Parameters:
- DATA_W, 32, payload width (instruction or bundled stage fields).
- EXC_W, 5, exception-code width; 0 code = no exception.
- RESET_PC, 32'h0000_3000, out_pc value after reset.
- SKID_EN, 1, 1 = 2-entry skid buffer, 0 = single entry with combinational in_ready.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-low: reset==0 at posedge clears state.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept this cycle.
- in_data  in  DATA_W  payload.
- in_pc  in  32  entry PC.
- in_exc  in  EXC_W  entry exception code.
- in_bd  in  1  entry is in a delay slot.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts head.
- out_data  out  DATA_W  head payload.
- out_pc  out  32  head PC, or redirect PC when bubble.
- out_exc  out  EXC_W  head exception code.
- out_bd  out  1  head delay-slot flag.
- req  in  1  interrupt/exception taken.
- eret  in  1  ERET committing.
- ebase  in  32  handler address.
- epc  in  32  return address.
- flush  in  1  generic kill, e.g. mispredict.
- occupancy  out  2  entries held, 0..2.

Behaviour:
- Reset (reset==0 at posedge): out_valid=0, out_data=0, out_exc=0, out_bd=0, out_pc=RESET_PC, occupancy=0, skid empty. in_ready=1 afterwards.
- Storage: head entry H drives all out_* registers directly. Skid entry S is present only when SKID_EN=1.
- Accept = in_valid & in_ready. Pop = out_valid & out_ready.
- SKID_EN=1:
  - in_ready = !S.valid; registered only, no path from out_ready.
  - Accept & (!H.valid | Pop): load into H.
  - Accept & H.valid & !Pop: load into S.
  - Pop & S.valid: S moves into H, S clears.
  - Pop & !S.valid & !Accept: H.valid=0; out_pc/out_data hold their last values.
- SKID_EN=0: in_ready = !H.valid | out_ready (combinational). Otherwise behaves like SKID_EN=1 with S absent.
- Latency: one cycle from Accept to out_valid when the stage is empty.
- Throughput: one entry per cycle while out_ready=1.
- Redirect priority, evaluated each posedge: req > eret > flush > handshake.
  - req: H and S cleared. out_valid=0, out_data=0, out_exc=0, out_bd=0, out_pc=ebase, occupancy=0.
  - eret (no req): same as req, but out_pc=epc.
  - flush (no req/eret): H and S cleared, valid=0, data/exc/bd=0. out_pc holds its current value.
  - An Accept in the same cycle as any redirect is discarded. A Pop in that cycle still counts downstream.
- Payload is stored verbatim, with no width conversion. A nonzero in_exc does not alter the handshake.
- occupancy = H.valid + S.valid, updated in the same cycle as the entries. It is never 2 when SKID_EN=0.
- Reset overrides redirects. Reset asserted mid-transfer discards all held entries.
- Invariant: S.valid implies H.valid, i.e. no hole at the head.

Test Plan:
- Reset release, then in_valid=1 with in_data=0x2402_0005 and in_pc=0x3000, out_ready=1 -> next cycle out_valid=1, out_data=0x2402_0005, out_pc=0x3000; occupancy=1; before the first transfer out_pc=0x3000.
- SKID_EN=1, out_ready=0, feed pc 0x3000 then 0x3004 -> occupancy=2 and in_ready=0; third entry 0x3008 held upstream. Raise out_ready -> heads 0x3000, 0x3004, 0x3008 on consecutive cycles with no loss or duplication.
- Stage holding 2 entries, req=1 and eret=1 in the same cycle, ebase=0x4180, epc=0x3010 -> out_valid=0, out_data=0, out_pc=0x4180, occupancy=0, in_ready=1.
- eret=1 alone with epc=0x300C while in_valid=1 (pc 0x3020) -> out_pc=0x300C, out_valid=0; the 0x3020 entry is not captured.
- flush=1 with head pc 0x3040 -> out_valid=0, out_pc stays 0x3040, occupancy=0.
- SKID_EN=0, head valid, out_ready toggled 1/0/1 -> in_ready equals out_ready in the same cycle; reset driven to 0 mid-stream -> all outputs return to reset values at the next posedge.
